// File: rtl/shot_ctrl_if.sv
// Bundle of the gun controller's button, coordinate and status signals.
// The bench drives through master; shot_ctrl sits on slave.
interface shot_ctrl_if #(
  parameter int unsigned W = 11
);
  logic         fire;
  logic         reload;
  logic [3:0]   dir_but_in;
  logic [W-1:0] sniper_x;
  logic [W-1:0] sniper_y;
  logic [W-1:0] duck_x;
  logic [W-1:0] duck_y;
  logic         duck_alive;
  logic [3:0]   dir_but_out;
  logic         flash;
  logic         hit;
  logic         miss;
  logic         dry_fire;
  logic         reload_done;
  logic [1:0]   ammo;
  logic [7:0]   hit_count;

  modport master (
    output fire, reload, dir_but_in, sniper_x, sniper_y, duck_x, duck_y, duck_alive,
    input  dir_but_out, flash, hit, miss, dry_fire, reload_done, ammo, hit_count
  );

  modport slave (
    input  fire, reload, dir_but_in, sniper_x, sniper_y, duck_x, duck_y, duck_alive,
    output dir_but_out, flash, hit, miss, dry_fire, reload_done, ammo, hit_count
  );
endinterface

// File: rtl/shot_ctrl.sv
// Frame-rate gun controller: trigger/reload edge detection, hit judgement against the
// duck window, ammo bookkeeping and flash/cooldown/reload timing with aim freeze.
module shot_ctrl #(
  parameter int unsigned W             = 11,
  parameter int unsigned AMMO_MAX      = 3,
  parameter int unsigned HIT_HALF      = 24,
  parameter int unsigned FLASH_FRAMES  = 4,
  parameter int unsigned COOL_FRAMES   = 12,
  parameter int unsigned RELOAD_FRAMES = 60
) (
  input logic        clk_slw,
  input logic        rst,
  shot_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StFire, StCool, StReload} state_e;

  localparam logic [1:0] AmmoMax  = 2'(AMMO_MAX);
  localparam logic [7:0] FlashLd  = 8'(FLASH_FRAMES - 1);
  localparam logic [7:0] CoolLd   = 8'(COOL_FRAMES - 1);
  localparam logic [7:0] ReloadLd = 8'(RELOAD_FRAMES - 1);
  localparam logic [W:0] HitHalf  = (W+1)'(HIT_HALF);

  state_e     state_q;
  logic [7:0] cnt_q;
  logic [1:0] ammo_q;
  logic [7:0] hit_count_q;
  logic       fire_q, reload_q;
  logic       hit_q, miss_q, dry_q, done_q;

  logic fire_e, reload_e;
  assign fire_e   = bus.fire & ~fire_q;
  assign reload_e = bus.reload & ~reload_q;

  // One extra bit with zero-extended operands keeps 0 vs 2^W-1 from wrapping.
  logic signed [W:0] dx, dy;
  logic        [W:0] adx, ady;
  logic              in_win;
  assign dx     = $signed({1'b0, bus.sniper_x}) - $signed({1'b0, bus.duck_x});
  assign dy     = $signed({1'b0, bus.sniper_y}) - $signed({1'b0, bus.duck_y});
  assign adx    = dx[W] ? $unsigned(-dx) : $unsigned(dx);
  assign ady    = dy[W] ? $unsigned(-dy) : $unsigned(dy);
  assign in_win = bus.duck_alive && (adx <= HitHalf) && (ady <= HitHalf);

  always_ff @(posedge clk_slw) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= 8'd0;
      ammo_q      <= AmmoMax;
      hit_count_q <= 8'd0;
      fire_q      <= 1'b1;
      reload_q    <= 1'b1;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      dry_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      fire_q   <= bus.fire;
      reload_q <= bus.reload;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
      dry_q    <= 1'b0;
      done_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (fire_e) begin
            if (ammo_q != 2'd0) begin
              ammo_q  <= ammo_q - 2'd1;
              state_q <= StFire;
              cnt_q   <= FlashLd;
              if (in_win) begin
                hit_q <= 1'b1;
                if (hit_count_q != 8'hFF) hit_count_q <= hit_count_q + 8'd1;
              end else begin
                miss_q <= 1'b1;
              end
            end else begin
              dry_q   <= 1'b1;
              state_q <= StReload;
              cnt_q   <= ReloadLd;
            end
          end else if (reload_e && (ammo_q < AmmoMax)) begin
            state_q <= StReload;
            cnt_q   <= ReloadLd;
          end
        end
        StFire: begin
          if (cnt_q == 8'd0) begin
            state_q <= StCool;
            cnt_q   <= CoolLd;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        StCool: begin
          if (cnt_q == 8'd0) begin
            if (ammo_q != 2'd0) begin
              state_q <= StIdle;
            end else begin
              state_q <= StReload;
              cnt_q   <= ReloadLd;
            end
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        StReload: begin
          if (cnt_q == 8'd0) begin
            ammo_q  <= AmmoMax;
            done_q  <= 1'b1;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Aim freeze is combinational so the crosshair stops on the very first flash frame.
  assign bus.dir_but_out = (state_q == StFire) ? 4'b0000 : bus.dir_but_in;
  assign bus.flash       = (state_q == StFire);
  assign bus.hit         = hit_q;
  assign bus.miss        = miss_q;
  assign bus.dry_fire    = dry_q;
  assign bus.reload_done = done_q;
  assign bus.ammo        = ammo_q;
  assign bus.hit_count   = hit_count_q;

endmodule

// File: tb/tb_shot_ctrl.sv
// Directed plus randomized bench for shot_ctrl against a timeline model of the gun.
module tb_shot_ctrl;
  localparam int W  = 11;
  localparam int AM = 3;
  localparam int HH = 24;
  localparam int FF = 4;
  localparam int CF = 12;
  localparam int RF = 60;

  logic clk = 1'b0;
  logic rst = 1'b0;

  shot_ctrl_if #(.W(W)) bus ();

  shot_ctrl #(
    .W(W), .AMMO_MAX(AM), .HIT_HALF(HH),
    .FLASH_FRAMES(FF), .COOL_FRAMES(CF), .RELOAD_FRAMES(RF)
  ) dut (
    .clk_slw(clk),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Timeline model: absolute edge numbers at which the gun is free again,
  // when a reload completes, and when the current flash started.
  longint k;
  int     m_ammo, m_hits;
  bit     m_hit, m_miss, m_dry, m_done;
  bit     pf, pr;
  longint idle_at, done_at, flash_lo;

  function automatic bit in_window(int sx, int sy, int dxp, int dyp, bit alive);
    int ax = sx - dxp;
    int ay = sy - dyp;
    if (ax < 0) ax = -ax;
    if (ay < 0) ay = -ay;
    return alive && (ax <= HH) && (ay <= HH);
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d (edge %0d)", tag, obs, exp, k);
    end
  endtask

  task automatic model_reset();
    m_ammo   = AM;
    m_hits   = 0;
    pf       = 1'b1;
    pr       = 1'b1;
    idle_at  = k + 1;
    done_at  = -1;
    flash_lo = -1000;
    {m_hit, m_miss, m_dry, m_done} = 4'b0;
  endtask

  task automatic model_edge(input bit f, input bit r, input bit rs, input int sx, input int sy,
                            input int dxp, input int dyp, input bit alive);
    bit fe, re;
    if (!rs) begin
      model_reset();
      return;
    end
    fe = f & ~pf;
    re = r & ~pr;
    pf = f;
    pr = r;
    {m_hit, m_miss, m_dry, m_done} = 4'b0;
    if (k == done_at) begin
      m_ammo = AM;
      m_done = 1'b1;
    end else if (k >= idle_at) begin
      if (fe && m_ammo > 0) begin
        m_ammo--;
        if (in_window(sx, sy, dxp, dyp, alive)) begin
          m_hit = 1'b1;
          if (m_hits < 255) m_hits++;
        end else begin
          m_miss = 1'b1;
        end
        flash_lo = k;
        idle_at  = k + FF + CF + 1;
        if (m_ammo == 0) begin
          done_at = k + FF + CF + RF;
          idle_at = done_at + 1;
        end
      end else if (fe) begin
        m_dry   = 1'b1;
        done_at = k + RF;
        idle_at = done_at + 1;
      end else if (re && m_ammo < AM) begin
        done_at = k + RF;
        idle_at = done_at + 1;
      end
    end
  endtask

  task automatic step();
    bit f = bus.fire;
    bit r = bus.reload;
    bit rs = rst;
    int sx = int'(bus.sniper_x);
    int sy = int'(bus.sniper_y);
    int dxp = int'(bus.duck_x);
    int dyp = int'(bus.duck_y);
    bit al = bus.duck_alive;
    bit m_flash;
    @(posedge clk);
    #1;
    k++;
    model_edge(f, r, rs, sx, sy, dxp, dyp, al);
    m_flash = (k >= flash_lo) && (k < flash_lo + FF);
    chk("hit", int'(bus.hit), int'(m_hit));
    chk("miss", int'(bus.miss), int'(m_miss));
    chk("dry_fire", int'(bus.dry_fire), int'(m_dry));
    chk("reload_done", int'(bus.reload_done), int'(m_done));
    chk("ammo", int'(bus.ammo), m_ammo);
    chk("hit_count", int'(bus.hit_count), m_hits);
    chk("flash", int'(bus.flash), int'(m_flash));
    chk("dir_but_out", int'(bus.dir_but_out), m_flash ? 0 : int'(bus.dir_but_in));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_pos(input int sx, input int sy, input int dxp, input int dyp, input bit al);
    bus.sniper_x   = W'(sx);
    bus.sniper_y   = W'(sy);
    bus.duck_x     = W'(dxp);
    bus.duck_y     = W'(dyp);
    bus.duck_alive = al;
  endtask

  task automatic pulse_fire();
    bus.fire = 1'b1;
    step();
    bus.fire = 1'b0;
  endtask

  initial begin
    k = 0;
    model_reset();
    bus.fire       = 1'b0;
    bus.reload     = 1'b0;
    bus.dir_but_in = 4'b0010;
    set_pos(640, 400, 664, 376, 1'b1);

    rst = 1'b0;
    steps(2);
    chk("reset_ammo", int'(bus.ammo), AM);
    chk("reset_flash", int'(bus.flash), 0);
    rst = 1'b1;

    // Hit exactly on the window corner, flash and aim freeze
    steps(2);
    pulse_fire();
    chk("edge_hit", int'(bus.hit), 1);
    chk("edge_ammo", int'(bus.ammo), 2);
    step();
    chk("freeze_dir", int'(bus.dir_but_out), 0);
    steps(20);

    // Misses: one pixel outside, far edge without wrap
    set_pos(640, 400, 665, 400, 1'b1);
    pulse_fire();
    chk("outside_miss", int'(bus.miss), 1);
    steps(20);
    set_pos(0, 400, 2000, 400, 1'b1);
    pulse_fire();
    chk("wrap_miss", int'(bus.miss), 1);
    steps(RF + 20);
    chk("auto_reload_ammo", int'(bus.ammo), AM);
    set_pos(500, 500, 500, 500, 1'b0);
    pulse_fire();
    chk("dead_miss", int'(bus.miss), 1);
    steps(20);

    // Three shots with fire held high, then poke fire during reload
    set_pos(300, 300, 310, 290, 1'b1);
    for (int s = 0; s < 3; s++) begin
      bus.fire = 1'b1;
      steps(20);
      bus.fire = 1'b0;
      step();
    end
    for (int s = 0; s < 4; s++) begin
      pulse_fire();
      steps(3);
    end
    steps(RF);
    chk("three_shot_reload", int'(bus.ammo), AM);

    // Manual reload at ammo 2, ignored reload at full ammo
    pulse_fire();
    steps(20);
    bus.reload = 1'b1;
    step();
    bus.reload = 1'b0;
    steps(RF + 3);
    bus.reload = 1'b1;
    step();
    bus.reload = 1'b0;
    steps(3);

    // Simultaneous fire and reload edges at ammo 2
    pulse_fire();
    steps(20);
    bus.fire   = 1'b1;
    bus.reload = 1'b1;
    step();
    chk("simul_ammo", int'(bus.ammo), 1);
    bus.fire   = 1'b0;
    bus.reload = 1'b0;
    steps(20);

    // Reset in the middle of the flash with fire held high
    bus.fire = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    chk("mid_reset_flash", int'(bus.flash), 0);
    chk("mid_reset_hits", int'(bus.hit_count), 0);
    rst = 1'b1;
    steps(5);
    bus.fire = 1'b0;
    step();
    pulse_fire();
    steps(20);

    // Randomized play
    for (int i = 0; i < 4000; i++) begin
      int dxp = int'($urandom_range(0, 2047));
      int dyp = int'($urandom_range(0, 2047));
      int sx, sy;
      if ($urandom_range(0, 3) != 0) begin
        sx = dxp + int'($urandom_range(0, 60)) - 30;
        sy = dyp + int'($urandom_range(0, 60)) - 30;
        if (sx < 0) sx = 0;
        if (sx > 2047) sx = 2047;
        if (sy < 0) sy = 0;
        if (sy > 2047) sy = 2047;
      end else begin
        sx = int'($urandom_range(0, 2047));
        sy = int'($urandom_range(0, 2047));
      end
      set_pos(sx, sy, dxp, dyp, $urandom_range(0, 7) != 0);
      bus.dir_but_in = 4'($urandom);
      if ($urandom_range(0, 3) == 0) bus.fire = ~bus.fire;
      if ($urandom_range(0, 15) == 0) bus.reload = ~bus.reload;
      rst = ($urandom_range(0, 299) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
